slavefifo2b_pad_if: RTL
=======================

Name: slavefifo2b_pad_if

Overview:
- Pin-side stage between the FX3 Slave FIFO 2-bit interface and the mode engines (loopback, stream-in, stream-out).
- Registers the incoming flags and data, then hands them to the engines.
- Muxes the engines' strobes, address and write data onto registered pin outputs.
- Runs a mode-switch FSM so the mode only changes after the bus has gone quiet.

Parameters:
- DATA_W, 32, FX3 data bus width.
- ADDR_RD, 2'b11, faddr value while the active engine selects its read socket.
- ADDR_WR, 2'b00, faddr value otherwise.
- DRAIN_CYCLES, 4, consecutive all-strobes-idle cycles required before a mode switch (range 1..15).

Ports:
- clk_100  in  1  interface clock, 100 MHz
- reset  in  1  asynchronous, active-high
- mode_req  in  2  requested mode: 0 idle, 1 loopback, 2 stream-in, 3 stream-out
- flaga, flagb, flagc, flagd  in  1 each  raw FX3 flags
- data_pin_in  in  DATA_W  FX3 bus, input path
- data_pin_out  out  DATA_W  FX3 bus, drive value
- data_pin_oe  out  1  bus drive enable
- faddr  out  2  FX3 socket address
- slcs_, slrd_, sloe_, slwr_, pktend_  out  1 each  FX3 strobes, active-low
- flaga_d, flagb_d, flagc_d, flagd_d  out  1 each  registered flags to the engines
- data_in_loopback  out  DATA_W  registered capture of data_pin_in
- mode_active  out  2  currently granted mode
- loopback_mode_selected, streamin_mode_selected, streamout_mode_selected  out  1 each  one-hot grants
- lb_slrd_, lb_sloe_, lb_slwr_, lb_rd_select  in  1 each  loopback engine controls
- lb_data_out  in  DATA_W  loopback engine write data
- si_slwr_, si_pktend_  in  1 each  stream-in engine controls
- si_data  in  DATA_W  stream-in engine write data
- so_slrd_, so_sloe_, so_rd_select  in  1 each  stream-out engine controls

Behaviour:
- Reset values:
  - slrd_, sloe_, slwr_, pktend_, slcs_ = 1.
  - data_pin_oe = 0; data_pin_out = 0; faddr = ADDR_WR.
  - flag*_d = 0; data_in_loopback = 0; mode_active = 0; all *_selected = 0; FSM in IDLE; drain counter = 0.
  - Reset asserted mid-transfer forces these values immediately (asynchronously).
- Input path: flag*_d and data_in_loopback are registered every cycle, 1-cycle latency, unconditionally.
- Owner mux: owner = mode_active. Owner signals are registered to the pins with 1-cycle latency.
  - Mode 1 (loopback): slrd_ = lb_slrd_, sloe_ = lb_sloe_, slwr_ = lb_slwr_, pktend_ = 1. faddr = ADDR_RD if lb_rd_select, else ADDR_WR. data_pin_out = lb_data_out. data_pin_oe = !lb_rd_select.
  - Mode 2 (stream-in): slrd_ = sloe_ = 1, slwr_ = si_slwr_, pktend_ = si_pktend_, faddr = ADDR_WR, data_pin_out = si_data, data_pin_oe = 1.
  - Mode 3 (stream-out): slrd_ = so_slrd_, sloe_ = so_sloe_, slwr_ = pktend_ = 1. faddr = ADDR_RD if so_rd_select, else ADDR_WR. data_pin_oe = 0.
  - Mode 0: all strobes 1, data_pin_oe = 0, data_pin_out holds its last value.
  - slcs_ = 0 when mode_active != 0, else 1.
  - Invariant: data_pin_oe = 1 and sloe_ = 0 never occur in the same cycle; in that case data_pin_oe is forced 0.
- Mode FSM states: IDLE, ACTIVE, DRAIN.
  - IDLE: mode_req != 0 → load mode_active = mode_req, go ACTIVE.
  - ACTIVE: the matching *_selected = 1. mode_req != mode_active → go DRAIN and deassert all *_selected in the same transition.
  - DRAIN: the owner keeps driving the pins so an in-flight burst completes.
    - idle = owner's slrd_, sloe_, slwr_, pktend_ inputs all 1.
    - Counter increments while idle and clears to 0 on any non-idle cycle.
    - At count == DRAIN_CYCLES-1 with idle: mode_active = mode_req, then go ACTIVE if it is non-zero, else IDLE. Counter clears.
  - mode_req changing again during DRAIN: the latest value at exit is taken. If it equals the old mode, the FSM still completes the drain, then re-enters ACTIVE.
- *_selected are registered and change on the same edge as mode_active.

Test Plan:
- Reset: assert reset mid-cycle with lb_slwr_ = 0 → all pin strobes 1, data_pin_oe = 0 and slcs_ = 1 immediately; mode_active = 0.
- Loopback grant: mode_req = 1 → one cycle later mode_active = 1 and loopback_mode_selected = 1. Then lb_rd_select = 1, lb_slrd_ = 0 → next cycle faddr = 2'b11, slrd_ = 0, data_pin_oe = 0.
- Flag/data capture: flagc = 1 and data_pin_in = 32'hA5A5_0001 at cycle n → flagc_d = 1 and data_in_loopback = 32'hA5A5_0001 at n+1.
- Stream-in write: mode 2, si_data = 32'h1234_5678, si_slwr_ = 0 for 3 cycles → slwr_ low for exactly 3 cycles, each 1 cycle later; data_pin_oe = 1; faddr = 2'b00.
- Drain with busy owner: in mode 1 with lb_slwr_ = 0, switch mode_req to 3; hold lb_slwr_ low 5 more cycles → mode_active stays 1 until 4 idle cycles have elapsed, then becomes 3. slwr_ follows lb_slwr_ throughout.
- Drain restart: during DRAIN, pulse lb_sloe_ = 0 for 1 cycle after 2 idle cycles → counter clears; the switch occurs 4 idle cycles after the pulse.

Source files
------------

// File: rtl/slavefifo2b_pad_if.sv
// FX3 Slave FIFO 2-bit pin stage: registers flags and data in, muxes the
// active engine onto registered pins, and only switches mode once the bus is quiet.
module slavefifo2b_pad_if #(
    parameter int         DATA_W       = 32,
    parameter logic [1:0] ADDR_RD      = 2'b11,
    parameter logic [1:0] ADDR_WR      = 2'b00,
    parameter int         DRAIN_CYCLES = 4
) (
    input  logic              clk_100,
    input  logic              reset,
    input  logic [1:0]        mode_req,
    input  logic              flaga,
    input  logic              flagb,
    input  logic              flagc,
    input  logic              flagd,
    input  logic [DATA_W-1:0] data_pin_in,
    output logic [DATA_W-1:0] data_pin_out,
    output logic              data_pin_oe,
    output logic [1:0]        faddr,
    output logic              slcs_,
    output logic              slrd_,
    output logic              sloe_,
    output logic              slwr_,
    output logic              pktend_,
    output logic              flaga_d,
    output logic              flagb_d,
    output logic              flagc_d,
    output logic              flagd_d,
    output logic [DATA_W-1:0] data_in_loopback,
    output logic [1:0]        mode_active,
    output logic              loopback_mode_selected,
    output logic              streamin_mode_selected,
    output logic              streamout_mode_selected,
    input  logic              lb_slrd_,
    input  logic              lb_sloe_,
    input  logic              lb_slwr_,
    input  logic              lb_rd_select,
    input  logic [DATA_W-1:0] lb_data_out,
    input  logic              si_slwr_,
    input  logic              si_pktend_,
    input  logic [DATA_W-1:0] si_data,
    input  logic              so_slrd_,
    input  logic              so_sloe_,
    input  logic              so_rd_select
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(DRAIN_CYCLES - 1);

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [2:0]        sel_q, sel_d;
    logic [3:0]        cnt_q, cnt_d;

    logic              slrd_q, sloe_q, slwr_q, pktend_q, oe_q;
    logic [1:0]        faddr_q;
    logic [DATA_W-1:0] dout_q;
    logic [3:0]        flags_q;
    logic [DATA_W-1:0] din_q;

    logic              own_slrd, own_sloe, own_slwr, own_pktend, own_oe;
    logic [1:0]        own_faddr;
    logic [DATA_W-1:0] own_dout;
    logic              own_idle;
    logic              oe_d;

    // {loopback, stream-in, stream-out}
    function automatic logic [2:0] grant(input logic [1:0] m);
        return {m == 2'd1, m == 2'd2, m == 2'd3};
    endfunction

    always_comb begin
        own_slrd   = 1'b1;
        own_sloe   = 1'b1;
        own_slwr   = 1'b1;
        own_pktend = 1'b1;
        own_faddr  = ADDR_WR;
        own_oe     = 1'b0;
        own_dout   = dout_q;
        case (mode_q)
            2'd1: begin
                own_slrd  = lb_slrd_;
                own_sloe  = lb_sloe_;
                own_slwr  = lb_slwr_;
                own_faddr = lb_rd_select ? ADDR_RD : ADDR_WR;
                own_dout  = lb_data_out;
                own_oe    = !lb_rd_select;
            end
            2'd2: begin
                own_slwr   = si_slwr_;
                own_pktend = si_pktend_;
                own_dout   = si_data;
                own_oe     = 1'b1;
            end
            2'd3: begin
                own_slrd  = so_slrd_;
                own_sloe  = so_sloe_;
                own_faddr = so_rd_select ? ADDR_RD : ADDR_WR;
            end
            default: ;
        endcase
    end

    assign own_idle = own_slrd & own_sloe & own_slwr & own_pktend;
    // Never drive the bus while the FX3 is enabled to drive it.
    assign oe_d     = own_oe & own_sloe;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (mode_req != 2'd0) begin
                    mode_d  = mode_req;
                    sel_d   = grant(mode_req);
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (mode_req != mode_q) begin
                    sel_d   = 3'b000;
                    cnt_d   = 4'd0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!own_idle) begin
                    cnt_d = 4'd0;
                end else if (cnt_q == CNT_LAST) begin
                    mode_d  = mode_req;
                    sel_d   = grant(mode_req);
                    cnt_d   = 4'd0;
                    state_d = (mode_req != 2'd0) ? S_ACTIVE : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= 2'd0;
            sel_q   <= 3'b000;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            slrd_q   <= 1'b1;
            sloe_q   <= 1'b1;
            slwr_q   <= 1'b1;
            pktend_q <= 1'b1;
            oe_q     <= 1'b0;
            faddr_q  <= ADDR_WR;
            dout_q   <= '0;
            flags_q  <= 4'b0000;
            din_q    <= '0;
        end else begin
            slrd_q   <= own_slrd;
            sloe_q   <= own_sloe;
            slwr_q   <= own_slwr;
            pktend_q <= own_pktend;
            oe_q     <= oe_d;
            faddr_q  <= own_faddr;
            dout_q   <= own_dout;
            flags_q  <= {flaga, flagb, flagc, flagd};
            din_q    <= data_pin_in;
        end
    end

    assign slrd_        = slrd_q;
    assign sloe_        = sloe_q;
    assign slwr_        = slwr_q;
    assign pktend_      = pktend_q;
    assign data_pin_oe  = oe_q;
    assign faddr        = faddr_q;
    assign data_pin_out = dout_q;
    assign slcs_        = (mode_q == 2'd0);

    assign {flaga_d, flagb_d, flagc_d, flagd_d} = flags_q;
    assign data_in_loopback = din_q;

    assign mode_active             = mode_q;
    assign loopback_mode_selected  = sel_q[2];
    assign streamin_mode_selected  = sel_q[1];
    assign streamout_mode_selected = sel_q[0];

endmodule
